// File: rtl/legv8_enc_pkg.sv
// rtl/legv8_enc_pkg.sv - LEGv8 encoder formats, field geometry and buffer entry type
package legv8_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_CB = 3'd4
  } fmt_t;

  localparam int DADDR_W = 9;
  localparam int IMM12_W = 12;
  localparam int COND_W  = 19;
  localparam int BR_W    = 26;
  localparam int SHAMT_W = 6;

  localparam int RD_LSB    = 0;
  localparam int RN_LSB    = 5;
  localparam int CB_IMM_LSB = 5;
  localparam int I_IMM_LSB = 10;
  localparam int D_IMM_LSB = 12;
  localparam int RM_LSB    = 16;

  localparam int ENTRY_ADDR_W = 16;

  typedef struct packed {
    logic [31:0]             instr;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic                    err;
  } entry_t;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response handshake bundle for instr_encoder
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [10:0]       in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rn, in_rm, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rn, in_rm, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/imm_fits.sv
// rtl/imm_fits.sv - high when a 64-bit value is the sign extension of its low W bits
module imm_fits #(parameter int W = 9) (
  input  logic [63:0] in,
  output logic        fits
);
  wire unused_low = ^in[W-2:0];

  assign fits = (&in[63:W-1]) | ~(|in[63:W-1]);
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - LEGv8 word packer with 2-entry output FIFO; IMM_RANGE_CHECK_EN adds immediate range flags
module instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);

  fmt_t        fmt;
  logic [31:0] enc_instr;
  logic        illegal;
  logic        range_err;

  assign fmt = fmt_t'(bus.in_fmt);

  always_comb begin
    enc_instr = '0;
    illegal   = 1'b0;
    case (fmt)
      FMT_R:  enc_instr = {bus.in_opcode, bus.in_rm, bus.in_imm[SHAMT_W-1:0], bus.in_rn, bus.in_rd};
      FMT_I:  enc_instr = {bus.in_opcode[9:0], bus.in_imm[IMM12_W-1:0], bus.in_rn, bus.in_rd};
      FMT_D:  enc_instr = {bus.in_opcode, bus.in_imm[DADDR_W-1:0], 2'b00, bus.in_rn, bus.in_rd};
      FMT_B:  enc_instr = {bus.in_opcode[5:0], bus.in_imm[BR_W-1:0]};
      FMT_CB: enc_instr = {bus.in_opcode[7:0], bus.in_imm[COND_W-1:0], bus.in_rd};
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic fits_d, fits_i, fits_cb, fits_b;

  imm_fits #(.W(DADDR_W)) u_fits_d  (.in(bus.in_imm), .fits(fits_d));
  imm_fits #(.W(IMM12_W)) u_fits_i  (.in(bus.in_imm), .fits(fits_i));
  imm_fits #(.W(COND_W))  u_fits_cb (.in(bus.in_imm), .fits(fits_cb));
  imm_fits #(.W(BR_W))    u_fits_b  (.in(bus.in_imm), .fits(fits_b));

  // shamt is unsigned, so R only needs the bits above the 6-bit field clear
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_R:  range_err = |bus.in_imm[63:SHAMT_W];
      FMT_I:  range_err = ~fits_i;
      FMT_D:  range_err = ~fits_d;
      FMT_B:  range_err = ~fits_b;
      FMT_CB: range_err = ~fits_cb;
      default: range_err = 1'b0;
    endcase
  end
`else
  wire unused_imm_hi = ^bus.in_imm[63:BR_W];
  assign range_err = 1'b0;
`endif

  entry_t            mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              push;
  logic              pop;
  entry_t            new_entry;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (count != 2'd0) & bus.out_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.instr = enc_instr;
    new_entry.addr  = ENTRY_ADDR_W'(addr_q);
    new_entry.err   = illegal | range_err;
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !push)
      count_nxt = count - 2'd1;
  end

  // in_ready is taken from the next count so a pop only frees a slot one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      addr_q     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
        addr_q      <= addr_q + 1'b1;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      in_ready_q <= (count_nxt < 2'd2);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr].instr : 32'h0;
  assign bus.out_addr  = bus.out_valid ? mem[rd_ptr].addr[ADDR_W-1:0] : '0;
  assign bus.out_err   = bus.out_valid & mem[rd_ptr].err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(2)) bus2 ();

  instr_encoder #(.ADDR_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  instr_encoder #(.ADDR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [10:0] op, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_fmt    = f;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rn     = rn;
    bus.in_rm     = rm;
    bus.in_imm    = imm;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr,
                            input logic [7:0] addr, input logic err);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_instr"}, 64'(bus.out_instr), 64'(instr));
    check({tag, "_addr"},  64'(bus.out_addr),  64'(addr));
    check({tag, "_err"},   64'(bus.out_err),   64'(err));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0;
    bus.in_rn = '0; bus.in_rm = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_fmt = '0; bus2.in_opcode = '0; bus2.in_rd = '0;
    bus2.in_rn = '0; bus2.in_rm = '0; bus2.in_imm = '0; bus2.out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_addr",  64'(bus.out_addr),  64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    expect_out("b_neg1", 32'h17FF_FFFF, 8'd0, 1'b0);

    send(3'd4, 11'h0B4, 5'd3, 5'd0, 5'd0, 64'd4);
    expect_out("cb", 32'hB400_0083, 8'd1, 1'b0);

    send(3'd2, 11'h7C2, 5'd2, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    expect_out("d_neg8", 32'hF85F_8022, 8'd2, 1'b0);
    send(3'd1, 11'h244, 5'd1, 5'd0, 5'd0, 64'd5);
    expect_out("i_add", 32'h9100_1401, 8'd3, 1'b0);

    send(3'd2, 11'h7C2, 5'd2, 5'd1, 5'd0, 64'd256);
    expect_out("d_256", 32'hF850_0022, 8'd4, RC);
    send(3'd7, 11'h7FF, 5'd31, 5'd31, 5'd31, 64'd1);
    expect_out("fmt7", 32'h0, 8'd5, 1'b1);
    send(3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 64'd0);
    expect_out("r_add", 32'h8B02_0023, 8'd6, 1'b0);
    send(3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 64'd64);
    expect_out("r_sh64", 32'h8B02_0023, 8'd7, RC);

    // Back-pressure: two fill the buffer, the third must wait
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd10);
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd11);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_instr", 64'(bus.out_instr), 64'h1400_000A);
    check("hold_addr",  64'(bus.out_addr),  64'd8);
    expect_out("bp_a", 32'h1400_000A, 8'd8, 1'b0);
    check("freed_in_ready", 64'(bus.in_ready), 64'd1);
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd12);
    expect_out("bp_b", 32'h1400_000B, 8'd9, 1'b0);
    expect_out("bp_c", 32'h1400_000C, 8'd10, 1'b0);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Push and pop in the same cycle with one entry held
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd20);
    bus.in_valid = 1'b1; bus.in_fmt = 3'd3; bus.in_opcode = 11'h005; bus.in_imm = 64'd21;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("pp_valid", 64'(bus.out_valid), 64'd1);
    check("pp_instr", 64'(bus.out_instr), 64'h1400_0015);
    check("pp_addr",  64'(bus.out_addr),  64'd12);
    check("pp_in_ready", 64'(bus.in_ready), 64'd1);
    expect_out("pp_pop", 32'h1400_0015, 8'd12, 1'b0);
    check("pp_empty", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset with a full buffer
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd30);
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd31);
    check("pre_rst_full", 64'(bus.in_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    check("arst_out_instr", 64'(bus.out_instr), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    send(3'd3, 11'h005, 5'd0, 5'd0, 5'd0, 64'd40);
    expect_out("post_rst", 32'h1400_0028, 8'd0, 1'b0);
    check("post_rst_empty", 64'(bus.out_valid), 64'd0);

    // Narrow counter wraps 3 -> 0
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_fmt = 3'd3; bus2.in_opcode = 11'h005;
      bus2.in_imm = 64'(i);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      check($sformatf("w2_valid%0d", i), 64'(bus2.out_valid), 64'd1);
      check($sformatf("w2_addr%0d", i),  64'(bus2.out_addr),  64'(i % 4));
      check($sformatf("w2_instr%0d", i), 64'(bus2.out_instr), 64'h1400_0000 + 64'(i));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
